// File: rtl/lr_shift_pipe_pkg.sv
// Shared types and helpers for the pipelined multi-mode shifter.
package lr_shift_pipe_pkg;

  localparam int MODE_W = 3;

  // Codes 5..7 are reserved and pass the data through untouched.
  typedef enum logic [MODE_W-1:0] {
    MODE_LEFT        = 3'd0,
    MODE_RIGHT       = 3'd1,
    MODE_ARITH_RIGHT = 3'd2,
    MODE_ROT_LEFT    = 3'd3,
    MODE_ROT_RIGHT   = 3'd4
  } shift_mode_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lr_shift_pipe_if.sv
// Valid/ready stream bundle: input words with shift controls, shifted results out.
interface lr_shift_pipe_if
  import lr_shift_pipe_pkg::*;
#(
  parameter int width = 8
);
  localparam int S = clog2(width);

  logic              iValid;
  logic              iReady;
  logic [width-1:0]  iBits;
  logic [S-1:0]      shift;
  logic [MODE_W-1:0] mode;
  logic              oValid;
  logic              oReady;
  logic [width-1:0]  oBits;

  modport master (
    output iValid, iBits, shift, mode, oReady,
    input  iReady, oValid, oBits
  );

  modport slave (
    input  iValid, iBits, shift, mode, oReady,
    output iReady, oValid, oBits
  );

endinterface

// File: rtl/lr_shift_stage.sv
// One log-shifter slice: conditionally shifts/rotates by 2^k and registers the beat.
module lr_shift_stage
  import lr_shift_pipe_pkg::*;
#(
  parameter int  width = 8,
  parameter int  k     = 0,
  localparam int S     = clog2(width)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [width-1:0]  in_data_i,
  input  logic [S-1:0]      in_shift_i,
  input  logic [MODE_W-1:0] in_mode_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [width-1:0]  out_data_o,
  output logic [S-1:0]      out_shift_o,
  output logic [MODE_W-1:0] out_mode_o
);

  localparam int D = 1 << k;

  logic              valid_q, valid_d;
  logic [width-1:0]  data_q, data_d;
  logic [S-1:0]      shift_q, shift_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [width-1:0]  shifted;
  logic              advance;
  logic              load;

  // Arithmetic right uses the current MSB: earlier stages never change it in that mode.
  always_comb begin
    // NOTE: default first so every path assigns and no latch is inferred.
    shifted = in_data_i;
    case (in_mode_i)
      MODE_LEFT:        shifted = {in_data_i[width-1-D:0], {D{1'b0}}};
      MODE_RIGHT:       shifted = {{D{1'b0}}, in_data_i[width-1:D]};
      MODE_ARITH_RIGHT: shifted = {{D{in_data_i[width-1]}}, in_data_i[width-1:D]};
      MODE_ROT_LEFT:    shifted = {in_data_i[width-1-D:0], in_data_i[width-1:width-D]};
      MODE_ROT_RIGHT:   shifted = {in_data_i[D-1:0], in_data_i[width-1:D]};
      default:          shifted = in_data_i;
    endcase
  end

  assign advance    = valid_q && out_ready_i;
  assign in_ready_o = !valid_q || advance;
  assign load       = in_valid_i && in_ready_o;

  // Data is left in place when the slice drains, so an empty pipe still shows the last result.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shift_d = shift_q;
    mode_d  = mode_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_shift_i[k] ? shifted : in_data_i;
      shift_d = in_shift_i;
      mode_d  = in_mode_i;
    end else if (advance) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: data is reset as well so the output bus reads zero out of reset.
      valid_q <= 1'b0;
      data_q  <= '0;
      shift_q <= '0;
      mode_q  <= '0;
    end else begin
      // NOTE: non-blocking so every slice loads from its neighbour's pre-edge value.
      valid_q <= valid_d;
      data_q  <= data_d;
      shift_q <= shift_d;
      mode_q  <= mode_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_shift_o = shift_q;
  assign out_mode_o  = mode_q;

endmodule

// File: rtl/lr_shift_pipe.sv
// Pipelined five-mode shifter: S log-shifter slices chained with collapsing valid/ready.
module lr_shift_pipe
  import lr_shift_pipe_pkg::*;
#(
  parameter int width = 8
) (
  input  logic            clk,
  input  logic            rst,
  lr_shift_pipe_if.slave  bus
);

  localparam int S = clog2(width);

  logic [S:0]        valid_c;
  logic [S-1:0]      ready_c;
  logic [S-1:0]      down_ready;
  logic [width-1:0]  data_c  [S+1];
  logic [S-1:0]      shift_c [S+1];
  logic [MODE_W-1:0] mode_c  [S+1];
  logic [2*S+MODE_W-1:0] unused_tail;

  assign valid_c[0] = bus.iValid;
  assign data_c[0]  = bus.iBits;
  assign shift_c[0] = bus.shift;
  assign mode_c[0]  = bus.mode;

  for (genvar g = 0; g < S; g++) begin : g_stage
    // Downstream can take a word if the sink is ready or any later slice has a hole.
    assign down_ready[g] = bus.oReady || !(&valid_c[S:g+1]);

    lr_shift_stage #(
      .width (width),
      .k     (g)
    ) u_stage (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (valid_c[g]),
      .in_ready_o  (ready_c[g]),
      .in_data_i   (data_c[g]),
      .in_shift_i  (shift_c[g]),
      .in_mode_i   (mode_c[g]),
      .out_valid_o (valid_c[g+1]),
      .out_ready_i (down_ready[g]),
      .out_data_o  (data_c[g+1]),
      .out_shift_o (shift_c[g+1]),
      .out_mode_o  (mode_c[g+1])
    );
  end

  assign bus.iReady = !rst && ready_c[0];
  assign bus.oValid = valid_c[S];
  assign bus.oBits  = data_c[S];

  assign unused_tail = {ready_c, shift_c[S], mode_c[S]};

endmodule
